// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle MIPS core: machine word, fetch sequencer
// states and next-PC source encodings.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    MEM    = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

  // Sign-extended, word-scaled branch displacement from imm16.
  function automatic word_t branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump or register.
module next_pc_calc
  import cpu_types_pkg::*;
(
  input  word_t      pc,
  input  word_t      instr,
  input  logic [1:0] PCSrc,
  input  logic       branch_taken,
  input  word_t      rs_data,
  output word_t      pc_plus4,
  output word_t      npc
);

  // Opcode bits and the low byte-offset of rs_data play no part in the target.
  logic unused_bits;
  assign unused_bits = ^{instr[31:26], rs_data[1:0]};

  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    npc = pc_plus4;
    case (PCSrc)
      PC_SEQ:  npc = pc_plus4;
      PC_BR:   if (branch_taken) npc = pc_plus4 + branch_offset(instr[15:0]);
      PC_JMP:  npc = {pc_plus4[31:28], instr[25:0], 2'b00};
      PC_JR:   npc = {rs_data[31:2], 2'b00};
      default: npc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Sequencing front end: PC, instruction latch and the FETCH/EXEC/MEM/HALTED
// state machine gating memory strobes and producing the retire pulse.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000
) (
  input  logic       CLK,
  input  logic       RST,
  output word_t      iaddr,
  output logic       iREN,
  input  logic       ihit,
  input  word_t      iload,
  output word_t      instr,
  output logic       instr_valid,
  input  logic       dREN_req,
  input  logic       dWEN_req,
  output logic       dREN,
  output logic       dWEN,
  input  logic       dhit,
  input  logic [1:0] PCSrc,
  input  logic       branch_taken,
  input  word_t      rs_data,
  input  logic       halt_req,
  output word_t      pc_plus4,
  output logic       commit,
  output logic       halt
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        instr_q, instr_d;
  logic         valid_q, valid_d;
  word_t        npc;

  next_pc_calc u_npc (
    .pc           (pc_q),
    .instr        (instr_q),
    .PCSrc        (PCSrc),
    .branch_taken (branch_taken),
    .rs_data      (rs_data),
    .pc_plus4     (pc_plus4),
    .npc          (npc)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    iREN    = 1'b0;
    dREN    = 1'b0;
    dWEN    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      FETCH: begin
        iREN = 1'b1;
        if (ihit) begin
          instr_d = iload;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (halt_req) begin
          state_d = HALTED;
        end else if (dREN_req || dWEN_req) begin
          state_d = MEM;
        end else begin
          commit  = 1'b1;
          pc_d    = npc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      MEM: begin
        // A store wins when the control unit asserts both strobes.
        dWEN = dWEN_req;
        dREN = dREN_req & ~dWEN_req;
        if (dhit) begin
          commit  = 1'b1;
          pc_d    = npc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      HALTED: ;
      default: state_d = FETCH;
    endcase
    // Reset must drop every strobe in the same cycle, not at the next edge.
    if (RST) begin
      iREN   = 1'b0;
      dREN   = 1'b0;
      dWEN   = 1'b0;
      commit = 1'b0;
    end
  end

  assign iaddr       = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halt        = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: driver pushes expected retirements, a
// negedge monitor pops them on commit and checks strobes and the next PC.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  typedef struct {
    word_t pc;
    word_t ins;
    word_t npc;
    logic  rd;
    logic  wr;
    int    dcyc;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST;
  word_t      iaddr, iload, instr, rs_data, pc_plus4;
  logic       iREN, ihit, instr_valid, dREN_req, dWEN_req, dREN, dWEN, dhit;
  logic [1:0] PCSrc;
  logic       branch_taken, halt_req, commit, halt;

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .iaddr(iaddr), .iREN(iREN), .ihit(ihit), .iload(iload),
    .instr(instr), .instr_valid(instr_valid), .dREN_req(dREN_req), .dWEN_req(dWEN_req),
    .dREN(dREN), .dWEN(dWEN), .dhit(dhit), .PCSrc(PCSrc), .branch_taken(branch_taken),
    .rs_data(rs_data), .halt_req(halt_req), .pc_plus4(pc_plus4), .commit(commit), .halt(halt)
  );

  always #5 CLK = ~CLK;

  int    nchk = 0;
  int    nerr = 0;
  exp_t  sb[$];
  word_t model_pc;
  logic  pend = 1'b0;
  word_t pend_npc;
  int    scnt = 0;

  localparam word_t ADDU = 32'h0109_5021;
  localparam word_t LW   = 32'h8D09_0000;
  localparam word_t BEQ  = 32'h1000_FFFE;
  localparam word_t JMP  = 32'h0800_0040;
  localparam word_t JR   = 32'h0320_0008;

  task automatic check(input string name, input word_t act, input word_t exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rules, in plain arithmetic.
  function automatic word_t model_npc(input word_t pc, input word_t ins, input logic [1:0] src,
                                      input logic bt, input word_t rs);
    word_t p4;
    int    off;
    p4  = pc + 32'd4;
    off = int'($signed(ins[15:0]));
    case (src)
      2'd0:    return p4;
      2'd1:    return bt ? p4 + 32'(off * 4) : p4;
      2'd2:    return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
      default: return rs & 32'hFFFF_FFFC;
    endcase
  endfunction

  // Monitor: strobes must match the instruction in flight; commit retires it.
  always @(negedge CLK) begin
    if (RST) begin
      pend = 1'b0;
      scnt = 0;
    end else begin
      if (iREN) check("iv_in_fetch", 32'(instr_valid), 32'd0);
      if (pend) begin
        check("next_iaddr", iaddr, pend_npc);
        pend = 1'b0;
      end
      if (dREN || dWEN) begin
        if (sb.size() == 0) check("stray_strobe", {30'd0, dREN, dWEN}, 32'd0);
        else begin
          check("dWEN", 32'(dWEN), 32'(sb[0].wr));
          check("dREN", 32'(dREN), 32'(sb[0].rd & ~sb[0].wr));
          scnt++;
        end
      end
      if (commit) begin
        if (sb.size() == 0) check("stray_commit", 32'(commit), 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("commit_pc", iaddr, e.pc);
          check("commit_instr", instr, e.ins);
          check("commit_valid", 32'(instr_valid), 32'd1);
          check("pc_plus4", pc_plus4, e.pc + 32'd4);
          check("mem_cycles", 32'(scnt), 32'(e.dcyc));
          pend     = 1'b1;
          pend_npc = e.npc;
        end
        scnt = 0;
      end
    end
  end

  // Entered and left one tick after a rising edge with the DUT in FETCH.
  task automatic run_instr(input word_t ins, input logic [1:0] src, input logic bt,
                           input word_t rs, input logic rd, input logic wr,
                           input int iw, input int dw);
    exp_t e;
    e.pc   = model_pc;
    e.ins  = ins;
    e.npc  = model_npc(model_pc, ins, src, bt, rs);
    e.rd   = rd;
    e.wr   = wr;
    e.dcyc = (rd || wr) ? dw + 1 : 0;
    sb.push_back(e);
    model_pc = e.npc;
    ihit = 1'b0; iload = $urandom; dhit = 1'($urandom_range(0, 1));
    repeat (iw) @(posedge CLK) #1;
    ihit = 1'b1; iload = ins; dhit = 1'b0;
    @(posedge CLK) #1;
    ihit = 1'($urandom_range(0, 1)); iload = $urandom;
    PCSrc = src; branch_taken = bt; rs_data = rs;
    dREN_req = rd; dWEN_req = wr;
    dhit = (rd || wr) ? 1'b0 : 1'($urandom_range(0, 1));
    @(posedge CLK) #1;
    if (rd || wr) begin
      repeat (dw) @(posedge CLK) #1;
      dhit = 1'b1;
      @(posedge CLK) #1;
    end
    ihit = 1'b0; dhit = 1'b0; dREN_req = 1'b0; dWEN_req = 1'b0;
  endtask

  task automatic check_pc(input string name, input word_t exp);
    @(negedge CLK);
    check(name, iaddr, exp);
  endtask

  task automatic pulse_reset();
    @(posedge CLK) #1;
    RST = 1'b1;
    @(posedge CLK) #1;
    RST = 1'b0;
    sb.delete();
    model_pc = 32'h0;
  endtask

  word_t exp_a[5] = '{32'd0, 32'd0, 32'd4, 32'd4, 32'd8};
  logic  exp_c[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    exp_t e;
    word_t frozen;
    RST = 1'b1; ihit = 1'b0; iload = '0; dREN_req = 1'b0; dWEN_req = 1'b0; dhit = 1'b0;
    PCSrc = PC_SEQ; branch_taken = 1'b0; rs_data = '0; halt_req = 1'b0;
    @(posedge CLK) #1;
    @(negedge CLK);
    check("rst_iREN", 32'(iREN), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    @(posedge CLK) #1;
    RST = 1'b0;
    check("rst_iaddr", iaddr, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_halt", 32'(halt), 32'd0);

    // ihit held high: ADDU stream at CPI 2.
    ihit = 1'b1; iload = ADDU;
    for (int k = 0; k < 3; k++) begin
      e.pc = 32'(4 * k); e.ins = ADDU; e.npc = 32'(4 * k + 4);
      e.rd = 1'b0; e.wr = 1'b0; e.dcyc = 0;
      sb.push_back(e);
    end
    model_pc = 32'd12;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("stream_iaddr", iaddr, exp_a[k]);
      check("stream_commit", 32'(commit), 32'(exp_c[k]));
      check("stream_valid", 32'(instr_valid), 32'(exp_c[k]));
    end
    @(posedge CLK) #1;
    ihit = 1'b0;
    @(posedge CLK) #1;

    run_instr(JR, PC_JR, 1'b0, 32'h10, 1'b0, 1'b0, 0, 0);
    run_instr(LW, PC_SEQ, 1'b0, 32'h0, 1'b1, 1'b0, 0, 3);
    check_pc("lw_next", 32'h14);
    run_instr(JR, PC_JR, 1'b0, 32'h20, 1'b0, 1'b0, 0, 0);
    run_instr(BEQ, PC_BR, 1'b1, 32'h0, 1'b0, 1'b0, 0, 0);
    check_pc("beq_taken", 32'h1C);
    run_instr(JR, PC_JR, 1'b0, 32'h20, 1'b0, 1'b0, 0, 0);
    run_instr(BEQ, PC_BR, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
    check_pc("beq_not_taken", 32'h24);
    run_instr(JR, PC_JR, 1'b0, 32'h4000_0000, 1'b0, 1'b0, 0, 0);
    run_instr(JMP, PC_JMP, 1'b0, 32'h0, 1'b0, 1'b0, 1, 0);
    check_pc("jump", 32'h4000_0100);
    run_instr(JR, PC_JR, 1'b0, 32'h0000_0103, 1'b0, 1'b0, 0, 0);
    check_pc("jr_align", 32'h100);
    run_instr(JR, PC_JR, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 0, 0);
    run_instr(ADDU, PC_SEQ, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
    check_pc("pc_wrap", 32'h0);

    // HALT beats a concurrent data request; nothing retires, PC frozen.
    frozen = model_pc;
    ihit = 1'b1; iload = 32'h0000_000C;
    @(posedge CLK) #1;
    ihit = 1'b0; halt_req = 1'b1; dREN_req = 1'b1;
    @(posedge CLK) #1;
    ihit = 1'b1; dhit = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      check("halt", 32'(halt), 32'd1);
      check("halt_strobes", {28'd0, iREN, dREN, dWEN, commit}, 32'd0);
      check("halt_iaddr", iaddr, frozen);
    end
    halt_req = 1'b0; dREN_req = 1'b0; ihit = 1'b0; dhit = 1'b0;
    pulse_reset();
    @(negedge CLK);
    check("halt_cleared", 32'(halt), 32'd0);
    check("halt_rst_iaddr", iaddr, 32'h0);

    for (int n = 0; n < 80; n++) begin
      int mk;
      mk = $urandom_range(0, 5);
      run_instr($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
                (mk == 1 || mk == 3), (mk == 2 || mk == 3),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset arriving mid-store.
    e.pc = model_pc; e.ins = 32'hAD09_0000; e.npc = model_pc + 32'd4;
    e.rd = 1'b0; e.wr = 1'b1; e.dcyc = 0;
    sb.push_back(e);
    ihit = 1'b1; iload = e.ins;
    @(posedge CLK) #1;
    ihit = 1'b0; dWEN_req = 1'b1; PCSrc = PC_SEQ;
    @(posedge CLK) #1;
    @(posedge CLK) #1;
    check("mem_dWEN", 32'(dWEN), 32'd1);
    RST = 1'b1;
    #4;
    check("rst_mem_dWEN", 32'(dWEN), 32'd0);
    check("rst_mem_other", {29'd0, dREN, iREN, commit}, 32'd0);
    @(posedge CLK) #1;
    RST = 1'b0; dWEN_req = 1'b0;
    sb.delete();
    model_pc = 32'h0;
    @(negedge CLK);
    check("rst_mem_iaddr", iaddr, 32'h0);
    check("rst_mem_halt", 32'(halt), 32'd0);
    check("rst_mem_valid", 32'(instr_valid), 32'd0);
    check("rst_mem_iREN", 32'(iREN), 32'd1);

    run_instr(ADDU, PC_SEQ, 1'b0, 32'h0, 1'b0, 1'b0, 0, 0);
    check_pc("after_rst", 32'h4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Sequencing front end of the multicycle MIPS core. Holds the PC, fetches instructions from the instruction port with an `iREN`/`ihit` handshake and presents the latched word to the control unit. Gates the data-port strobes requested by the control unit until `dhit`, then retires the instruction by pulsing `commit` and loading the next PC. Sits between the memory/cache interface and the control unit/datapath.

## Interface
- `PC_INIT`, 32'h0000_0000, PC value loaded on reset.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `iaddr`  out  32  current PC, drives the instruction address.
- `iREN`  out  1  instruction read request.
- `ihit`  in  1  instruction word valid on `iload` this cycle.
- `iload`  in  32  instruction word.
- `instr`  out  32  latched instruction, feeds opcode/funct decode.
- `instr_valid`  out  1  `instr` is current; control outputs are meaningful.
- `dREN_req`, `dWEN_req`  in  1 each  data strobes decoded by the control unit.
- `dREN`, `dWEN`  out  1 each  gated data strobes to memory.
- `dhit`  in  1  data access complete.
- `PCSrc`  in  2  next-PC select: 0 sequential, 1 branch, 2 jump, 3 register.
- `branch_taken`  in  1  resolved branch condition from the datapath, with BEQ/BNE polarity already applied.
- `rs_data`  in  32  register value for PCSrc=3.
- `halt_req`  in  1  decoded HALT.
- `pc_plus4`  out  32  PC+4, used as the JAL link value.
- `commit`  out  1  one-cycle retire pulse that enables register-file write.
- `halt`  out  1  sticky halt.

## Operation
- Reset (`RST`=1 at an edge) sets: state FETCH, `iaddr`=PC_INIT, `instr`=0, `instr_valid`=0, `halt`=0.
  - During reset, all combinational outputs read as reset values: `iREN`=0, `dREN`=`dWEN`=0, `commit`=0.
- States: FETCH, EXEC, MEM, HALTED.
- **FETCH**
  - `iREN`=1.
  - On `ihit`: latch `iload` into `instr`, set `instr_valid`, go to EXEC.
  - Otherwise stay in FETCH.
- **EXEC** (`iREN`=0)
  - Priority 1: `halt_req` goes to HALTED. PC is not updated and `commit`=0.
  - Priority 2: `dREN_req` or `dWEN_req` goes to MEM.
  - Otherwise: `commit`=1, PC is updated, go to FETCH.
- **MEM**
  - `dWEN`=`dWEN_req` and `dREN`=`dREN_req` & ~`dWEN_req`; write wins if both are requested.
  - On `dhit`: `commit`=1, PC is updated, go to FETCH.
  - Otherwise hold in MEM.
- **HALTED**
  - `halt`=1 and all strobes are 0.
  - The state is exited only by `RST`.
- `instr_valid` clears when FETCH is entered and is 0 throughout FETCH.
- Next PC (all arithmetic modulo 2^32):
  - PCSrc 0: `pc_plus4`.
  - PCSrc 1: `pc_plus4` + (sext(`instr[15:0]`)<<2) if `branch_taken`, else `pc_plus4`.
  - PCSrc 2: {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}.
  - PCSrc 3: {`rs_data[31:2]`, 2'b00}.
- Boundary conditions:
  - PC 32'hFFFF_FFFC with PCSrc 0 wraps to 0.
  - `ihit` outside FETCH and `dhit` outside MEM are ignored.
  - `RST` in MEM drops `dREN`/`dWEN` in the same cycle and reloads PC_INIT.

## Timing
- `ihit` in FETCH at cycle t: `instr` is valid from cycle t+1 (EXEC).
  - Non-memory instruction: `commit` in t+1, new `iaddr` in t+2.
  - Minimum CPI is 2 with zero-wait memory.
- Memory instruction: `dREN`/`dWEN` rise in t+2 (MEM).
  - `dhit` at cycle m gives `commit` in m and the next FETCH in m+1.
- PC, `instr` and state are updated only on the rising edge of `CLK`.
- `dREN`/`dWEN`/`iREN`/`commit` are combinational from state and inputs and are never high outside their own state.
- Inputs from the control unit and datapath (`PCSrc`, `branch_taken`, `rs_data`, `halt_req`) are sampled only in EXEC/MEM and must be stable there.

## Structure
- Add to `cpu_types_pkg`:
  - `fetch_state_t` enum {FETCH, EXEC, MEM, HALTED}.
  - PCSrc encodings PC_SEQ=0, PC_BR=1, PC_JMP=2, PC_JR=3.
  - Reuse `word_t`.
- One combinational sub-module, `next_pc_calc`.
  - Inputs: `pc`, `instr`, `PCSrc`, `branch_taken`, `rs_data`.
  - Outputs: `pc_plus4`, `npc`.
- State register, PC and `instr` latch live in `fetch_unit`.

## Test plan
- Reset, `ihit` tied high, ADDU stream: `iaddr` runs 0, 0, 4, 4, 8; `commit` every second cycle; `instr_valid`=0 in FETCH cycles.
- LW at 0x10, `dhit` held low 3 cycles: `dREN`=1 for exactly 4 cycles, `commit` on the `dhit` cycle, next `iaddr`=0x14; `dWEN` never 1.
- BEQ at 0x20, imm16=0xFFFE, `branch_taken`=1 → `iaddr`=0x1C.
- BEQ at 0x20, imm16=0xFFFE, `branch_taken`=0 → `iaddr`=0x24.
- J at 0x4000_0000 with target field 0x0000040 → `iaddr`=0x4000_0100.
- JR with `rs_data`=0x0000_0103 → `iaddr`=0x100.
- PC_INIT=32'hFFFF_FFFC, ADDU → next `iaddr`=0.
- HALT: `halt`=1 with no `commit` and `iaddr` frozen.
- `RST` pulse while in MEM with `dWEN`=1: `dWEN`=0 in the reset cycle, `iaddr`=PC_INIT, `halt`=0.
